// File: rtl/nvmm_latency_shim.sv
// AXI4 latency-injection stage: delays NVMM-region AR/AW requests by a programmable
// number of cycles, gates W behind issued AWs, and passes R/B straight through.

module nvmm_req_engine #(
    parameter int PAY_BITS = 61
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          lat_i,
    input  logic [2:0]          nvmm_begin_i,
    input  logic [2:0]          s_region_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [PAY_BITS-1:0] s_payload_i,
    input  logic                allow_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [PAY_BITS-1:0] m_payload_o,
    output logic [31:0]         nvmm_count_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [PAY_BITS-1:0] payload_q, payload_d;
    logic                nvmm_q, nvmm_d;
    logic [31:0]         count_q, count_d;
    logic                is_nvmm;
    logic [7:0]          delay;

    assign is_nvmm = (nvmm_begin_i != 3'd0) && (s_region_i >= nvmm_begin_i);
    assign delay   = is_nvmm ? lat_i : 8'd0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        nvmm_d    = nvmm_q;
        count_d   = count_q;
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    payload_d = s_payload_i;
                    nvmm_d    = is_nvmm;
                    cnt_d     = delay;
                    state_d   = (delay != 8'd0) ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // allow_i lets the owner hold back valid (W credit exhaustion) before it is ever raised
                m_valid_o = allow_i;
                if (allow_i && m_ready_i) begin
                    state_d = ST_IDLE;
                    if (nvmm_q) count_d = count_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            payload_q <= '0;
            nvmm_q    <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            nvmm_q    <= nvmm_d;
            count_q   <= count_d;
        end
    end

    assign m_payload_o  = payload_q;
    assign nvmm_count_o = count_q;
endmodule

module nvmm_latency_shim #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int STRB_BITS    = DATA_BITS / 8,
    parameter int ID_BITS      = 4,
    parameter int REGION_LSB   = 27,
    parameter int MAX_W_CREDIT = 15
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst,
    input  logic [7:0]           lat_fr,
    input  logic [7:0]           lat_fw,
    input  logic [2:0]           nvmm_begin,
    output logic [31:0]          cnt_nvmm_rd,
    output logic [31:0]          cnt_nvmm_wr,
    // upstream AR
    input  logic [ID_BITS-1:0]   s_axi_arid,
    input  logic [ADDR_BITS-1:0] s_axi_araddr,
    input  logic [7:0]           s_axi_arlen,
    input  logic [2:0]           s_axi_arsize,
    input  logic [1:0]           s_axi_arburst,
    input  logic                 s_axi_arlock,
    input  logic [3:0]           s_axi_arcache,
    input  logic [2:0]           s_axi_arprot,
    input  logic [3:0]           s_axi_arqos,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    // upstream AW
    input  logic [ID_BITS-1:0]   s_axi_awid,
    input  logic [ADDR_BITS-1:0] s_axi_awaddr,
    input  logic [7:0]           s_axi_awlen,
    input  logic [2:0]           s_axi_awsize,
    input  logic [1:0]           s_axi_awburst,
    input  logic                 s_axi_awlock,
    input  logic [3:0]           s_axi_awcache,
    input  logic [2:0]           s_axi_awprot,
    input  logic [3:0]           s_axi_awqos,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    // upstream W, R, B
    input  logic [DATA_BITS-1:0] s_axi_wdata,
    input  logic [STRB_BITS-1:0] s_axi_wstrb,
    input  logic                 s_axi_wlast,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [ID_BITS-1:0]   s_axi_rid,
    output logic [DATA_BITS-1:0] s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rlast,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [ID_BITS-1:0]   s_axi_bid,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    // downstream AR
    output logic [ID_BITS-1:0]   m_axi_arid,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arlock,
    output logic [3:0]           m_axi_arcache,
    output logic [2:0]           m_axi_arprot,
    output logic [3:0]           m_axi_arqos,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    // downstream AW
    output logic [ID_BITS-1:0]   m_axi_awid,
    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awlock,
    output logic [3:0]           m_axi_awcache,
    output logic [2:0]           m_axi_awprot,
    output logic [3:0]           m_axi_awqos,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    // downstream W, R, B
    output logic [DATA_BITS-1:0] m_axi_wdata,
    output logic [STRB_BITS-1:0] m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [ID_BITS-1:0]   m_axi_rid,
    input  logic [DATA_BITS-1:0] m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    input  logic [ID_BITS-1:0]   m_axi_bid,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready
);
    localparam int PAY_BITS = ID_BITS + ADDR_BITS + 25;

    logic [PAY_BITS-1:0] ar_pay_in, ar_pay_out, aw_pay_in, aw_pay_out;
    logic [3:0]          credit_q, credit_d;
    logic                w_open, aw_fire, wlast_fire, aw_allow;

    assign ar_pay_in = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
    assign aw_pay_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                        s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_pay_out;
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_pay_out;

    nvmm_req_engine #(.PAY_BITS(PAY_BITS)) u_ar_engine (
        .clk_i        (sys_clk_i),
        .rst_i        (sys_rst),
        .lat_i        (lat_fr),
        .nvmm_begin_i (nvmm_begin),
        .s_region_i   (s_axi_araddr[REGION_LSB+2:REGION_LSB]),
        .s_valid_i    (s_axi_arvalid),
        .s_ready_o    (s_axi_arready),
        .s_payload_i  (ar_pay_in),
        .allow_i      (1'b1),
        .m_valid_o    (m_axi_arvalid),
        .m_ready_i    (m_axi_arready),
        .m_payload_o  (ar_pay_out),
        .nvmm_count_o (cnt_nvmm_rd)
    );

    nvmm_req_engine #(.PAY_BITS(PAY_BITS)) u_aw_engine (
        .clk_i        (sys_clk_i),
        .rst_i        (sys_rst),
        .lat_i        (lat_fw),
        .nvmm_begin_i (nvmm_begin),
        .s_region_i   (s_axi_awaddr[REGION_LSB+2:REGION_LSB]),
        .s_valid_i    (s_axi_awvalid),
        .s_ready_o    (s_axi_awready),
        .s_payload_i  (aw_pay_in),
        .allow_i      (aw_allow),
        .m_valid_o    (m_axi_awvalid),
        .m_ready_i    (m_axi_awready),
        .m_payload_o  (aw_pay_out),
        .nvmm_count_o (cnt_nvmm_wr)
    );

    // Credit counts AWs already downstream whose W burst has not yet completed.
    assign w_open       = (credit_q != 4'd0);
    assign m_axi_wvalid = s_axi_wvalid && w_open;
    assign s_axi_wready = m_axi_wready && w_open;
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign aw_fire      = m_axi_awvalid && m_axi_awready;
    assign wlast_fire   = m_axi_wvalid && m_axi_wready && s_axi_wlast;
    assign aw_allow     = (credit_q != 4'(MAX_W_CREDIT)) || wlast_fire;

    always_comb begin
        credit_d = credit_q;
        if (aw_fire && !wlast_fire)      credit_d = credit_q + 4'd1;
        else if (!aw_fire && wlast_fire) credit_d = credit_q - 4'd1;
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst) begin
        if (sys_rst) credit_q <= 4'd0;
        else         credit_q <= credit_d;
    end

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
endmodule

// File: tb/tb_nvmm_latency_shim.sv
// Scoreboard bench for nvmm_latency_shim: expected AR/AW/W traffic is queued as
// stimulus is driven and popped as the downstream side handshakes.
`timescale 1ns/1ps
module tb_nvmm_latency_shim;
    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  lat_fr = 8'd0, lat_fw = 8'd0;
    logic [2:0]  nvmm_begin = 3'd4;
    logic [31:0] cnt_nvmm_rd, cnt_nvmm_wr;

    logic [3:0]  s_arid = '0, s_awid = '0;
    logic [31:0] s_araddr = '0, s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic        s_arvalid = 0, s_awvalid = 0, s_arready, s_awready;
    logic [63:0] s_wdata = '0;
    logic        s_wlast = 0, s_wvalid = 0, s_wready;
    logic [3:0]  s_rid, s_bid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_rlast, s_rvalid, s_bvalid;
    logic        s_rready = 0, s_bready = 0;

    logic [3:0]  m_arid, m_awid;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0]  m_arburst, m_awburst;
    logic        m_arlock, m_awlock;
    logic [3:0]  m_arcache, m_awcache, m_arqos, m_awqos;
    logic        m_arvalid, m_awvalid;
    logic        m_arready = 1, m_awready = 1;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready = 0;
    logic [3:0]  m_rid = '0, m_bid = '0;
    logic [63:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0, m_bresp = '0;
    logic        m_rlast = 0, m_rvalid = 0, m_bvalid = 0;
    logic        m_rready, m_bready;

    nvmm_latency_shim dut (
        .sys_clk_i(clk), .sys_rst(sys_rst), .lat_fr(lat_fr), .lat_fw(lat_fw),
        .nvmm_begin(nvmm_begin), .cnt_nvmm_rd(cnt_nvmm_rd), .cnt_nvmm_wr(cnt_nvmm_wr),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(8'd3), .s_axi_arsize(3'd3),
        .s_axi_arburst(2'b01), .s_axi_arlock(1'b0), .s_axi_arcache(4'd3), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(3'd3),
        .s_axi_awburst(2'b01), .s_axi_awlock(1'b0), .s_axi_awcache(4'd3), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(8'hFF), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
        .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache),
        .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
        .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache),
        .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        int          edge_n;   // expected downstream handshake edge, -1 = not timed
        bit          nvmm;
    } req_t;

    req_t        ar_q[$], aw_q[$];
    logic [64:0] w_q[$];
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0;
    int          exp_rd = 0, exp_wr = 0, model_credit = 0;
    req_t        mon_r;
    logic [64:0] mon_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit is_nvmm(input logic [31:0] addr);
        return (nvmm_begin != 3'd0) && (addr[29:27] >= nvmm_begin);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples just before each rising edge, well away from it.
    always @(negedge clk) begin
        #4;
        if (!sys_rst) begin
            if (m_arvalid && m_arready) begin
                if (ar_q.size() == 0) chk("ar_spurious", 1, 0);
                else begin
                    mon_r = ar_q.pop_front();
                    $display("AR issue addr=%08h id=%0d edge=%0d", m_araddr, m_arid, cyc + 1);
                    chk("ar_addr", m_araddr, mon_r.addr);
                    chk("ar_id", m_arid, mon_r.id);
                    if (mon_r.edge_n >= 0) chk("ar_edge", cyc + 1, mon_r.edge_n);
                    if (mon_r.nvmm) exp_rd++;
                end
            end
            if (m_wvalid && m_wready) begin
                chk("w_credit", model_credit != 0, 1);
                if (w_q.size() == 0) chk("w_spurious", 1, 0);
                else begin
                    mon_w = w_q.pop_front();
                    chk("w_data", m_wdata, mon_w[63:0]);
                    chk("w_last", m_wlast, mon_w[64]);
                end
            end
            if (m_awvalid && m_awready) begin
                if (aw_q.size() == 0) chk("aw_spurious", 1, 0);
                else begin
                    mon_r = aw_q.pop_front();
                    $display("AW issue addr=%08h id=%0d edge=%0d", m_awaddr, m_awid, cyc + 1);
                    chk("aw_addr", m_awaddr, mon_r.addr);
                    chk("aw_id", m_awid, mon_r.id);
                    if (mon_r.edge_n >= 0) chk("aw_edge", cyc + 1, mon_r.edge_n);
                    if (mon_r.nvmm) exp_wr++;
                end
                model_credit++;
            end
            if (m_wvalid && m_wready && m_wlast) model_credit--;
        end
    end

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id);
        req_t r;
        int   t = 0;
        @(negedge clk);
        s_arvalid = 1; s_araddr = addr; s_arid = id;
        #1;
        while (!s_arready && t < 1000) begin @(negedge clk); #1; t++; end
        if (t >= 1000) chk("ar_accept_timeout", 0, 1);
        else begin
            r.addr = addr; r.id = id; r.nvmm = is_nvmm(addr);
            r.edge_n = cyc + 2 + (r.nvmm ? int'(lat_fr) : 0);
            ar_q.push_back(r);
        end
        @(negedge clk);
        s_arvalid = 0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input bit timed);
        req_t r;
        int   t = 0;
        @(negedge clk);
        s_awvalid = 1; s_awaddr = addr; s_awid = id; s_awlen = len;
        #1;
        while (!s_awready && t < 1000) begin @(negedge clk); #1; t++; end
        if (t >= 1000) chk("aw_accept_timeout", 0, 1);
        else begin
            r.addr = addr; r.id = id; r.nvmm = is_nvmm(addr);
            r.edge_n = timed ? cyc + 2 + (r.nvmm ? int'(lat_fw) : 0) : -1;
            aw_q.push_back(r);
        end
        @(negedge clk);
        s_awvalid = 0;
    endtask

    task automatic send_w(input int beats, input logic [63:0] base);
        int t;
        for (int i = 0; i < beats; i++) begin
            @(negedge clk);
            s_wvalid = 1; s_wdata = base + 64'(i); s_wlast = (i == beats - 1);
            w_q.push_back({s_wlast, s_wdata});
            #1;
            t = 0;
            while (!s_wready && t < 1000) begin @(negedge clk); #1; t++; end
            if (t >= 1000) chk("w_accept_timeout", 0, 1);
        end
        @(negedge clk);
        s_wvalid = 0; s_wlast = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((ar_q.size() + aw_q.size() + w_q.size()) != 0 && t < 2000) begin
            @(negedge clk); t++;
        end
        chk("drain_timeout", t >= 2000, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [63:0] rpat;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arready", s_arready, 1);
        chk("rst_awready", s_awready, 1);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_cnt_rd", cnt_nvmm_rd, 0);
        @(negedge clk);
        sys_rst = 0;

        // DRAM pass-through read, then NVMM read with 20 cycles of delay
        nvmm_begin = 3'd4; lat_fr = 8'd20;
        send_ar(32'h0800_0000, 4'd1);
        wait_drain();
        chk("dram_cnt_rd", cnt_nvmm_rd, 0);
        send_ar(32'h3000_0000, 4'd2);
        wait_drain();
        chk("nvmm_cnt_rd", cnt_nvmm_rd, 1);

        // R and B pass straight through
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rpat = {$urandom, $urandom};
            m_rdata = rpat; m_rid = 4'(i + 5); m_rvalid = 1; s_rready = i[0];
            m_bid = 4'(i + 9); m_bvalid = i[0]; s_bready = 1;
            #1;
            chk("r_data", s_rdata, rpat);
            chk("r_id", s_rid, 4'(i + 5));
            chk("r_ready", m_rready, i[0]);
            chk("b_id_valid", {s_bid, s_bvalid}, {4'(i + 9), i[0]});
        end
        m_rvalid = 0; m_bvalid = 0;

        // NVMM write with W presented before AW
        lat_fw = 8'd5; m_wready = 1;
        fork
            send_w(8, 64'hA000);
            begin
                repeat (2) @(negedge clk);
                #1;
                chk("w_gated_ready", s_wready, 0);
                chk("w_gated_valid", m_wvalid, 0);
                send_aw(32'h3000_0100, 4'd3, 8'd7, 1);
            end
        join
        wait_drain();
        chk("nvmm_cnt_wr", cnt_nvmm_wr, 1);
        @(negedge clk);
        s_wvalid = 1; s_wlast = 1;
        #1;
        chk("w_credit_zero", s_wready, 0);
        @(negedge clk);
        s_wvalid = 0; s_wlast = 0;

        // Disabled NVMM: region 6 gets zero delay
        nvmm_begin = 3'd0;
        send_ar(32'h3000_0200, 4'd4);
        wait_drain();
        chk("dis_cnt_rd", cnt_nvmm_rd, 1);

        // lat_fr change during WAIT must not move the release edge
        nvmm_begin = 3'd4; lat_fr = 8'd10;
        send_ar(32'h3800_0000, 4'd5);
        lat_fr = 8'd100;
        wait_drain();

        // Maximum delay
        lat_fr = 8'd255;
        send_ar(32'h2000_0000, 4'd6);
        wait_drain();
        chk("max_cnt_rd", cnt_nvmm_rd, 3);

        // Simultaneous AR and AW
        lat_fr = 8'd0; lat_fw = 8'd0;
        fork
            send_ar(32'h0000_1000, 4'd7);
            send_aw(32'h0000_2000, 4'd8, 8'd0, 1);
            send_w(1, 64'hB000);
        join
        wait_drain();

        // Credit limit: 15 AWs with no W progress, the 16th is held
        m_wready = 0; nvmm_begin = 3'd0;
        for (int i = 0; i < 15; i++) send_aw(32'h0000_0000 + 32'(i * 64), 4'(i), 8'd0, 1);
        send_aw(32'h0001_0000, 4'hF, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("aw_held", m_awvalid, 0);
        end
        @(negedge clk);
        s_wvalid = 1; s_wlast = 1; s_wdata = 64'hC000;
        w_q.push_back({1'b1, 64'hC000});
        #1;
        chk("aw_held_noready", m_awvalid, 0);
        @(negedge clk);
        m_wready = 1;
        #1;
        chk("aw_release", m_awvalid, 1);
        @(negedge clk);
        s_wvalid = 0; s_wlast = 0;
        for (int i = 0; i < 15; i++) send_w(1, 64'hD000 + 64'(i * 16));
        wait_drain();

        // Asynchronous reset during an AR WAIT
        nvmm_begin = 3'd4; lat_fr = 8'd50; m_wready = 1;
        send_ar(32'h3000_0300, 4'd9);
        repeat (5) @(negedge clk);
        #2;
        sys_rst = 1;
        #1;
        chk("arst_arready", s_arready, 1);
        chk("arst_awready", s_awready, 1);
        chk("arst_arvalid", m_arvalid, 0);
        chk("arst_cnt_rd", cnt_nvmm_rd, 0);
        chk("arst_cnt_wr", cnt_nvmm_wr, 0);
        ar_q.delete(); aw_q.delete(); w_q.delete();
        exp_rd = 0; exp_wr = 0; model_credit = 0;
        s_wvalid = 1;
        #0;
        #1;
        chk("arst_wvalid_wready", {m_wvalid, s_wready}, 2'b00);
        s_wvalid = 0;
        repeat (2) @(negedge clk);
        sys_rst = 0;
        repeat (80) @(negedge clk);
        chk("post_rst_cnt_rd", cnt_nvmm_rd, exp_rd);
        chk("post_rst_cnt_wr", cnt_nvmm_wr, exp_wr);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/nvmm_latency_shim.md
# nvmm_latency_shim

AXI4 latency-injection stage placed directly upstream of the simulated DRAM slave. It holds each AR/AW request for a programmable number of cycles when the address falls in the NVMM region, so a DRAM backing store can emulate slower non-volatile memory. W is gated so that no write beat reaches the slave before its AW. R and B pass straight through, and per-direction NVMM request counters are exported.

## Interface
Parameters:
- ADDR_BITS, 32: AXI address width.
- DATA_BITS, 64: AXI data width. STRB_BITS = DATA_BITS/8.
- ID_BITS, 4: AXI ID width.
- REGION_LSB, 27: LSB of the 3-bit region field addr[REGION_LSB+2:REGION_LSB].
- MAX_W_CREDIT, 15: maximum number of issued AWs whose W burst is still incomplete.

Ports:
- sys_clk_i, in, 1: clock. Rising edge only.
- sys_rst, in, 1: asynchronous, active-high reset.
- lat_fr, in, 8: extra NVMM read latency, in cycles.
- lat_fw, in, 8: extra NVMM write latency, in cycles.
- nvmm_begin, in, 3: first NVMM region. 0 disables NVMM (all traffic is DRAM).
- cnt_nvmm_rd, out, 32: number of NVMM ARs issued downstream.
- cnt_nvmm_wr, out, 32: number of NVMM AWs issued downstream.
- s_axi_ar*/s_axi_aw*, in/out, standard: upstream slave AR and AW channels. Fields: id, addr, len, size, burst, lock, cache, prot, qos, valid, ready.
- s_axi_w*, s_axi_r*, s_axi_b*, in/out, standard: upstream slave W, R and B channels.
- m_axi_ar*, m_axi_aw*, m_axi_w*, m_axi_r*, m_axi_b*, mirrored: downstream master channels toward the DRAM model.

## Operation
- AR and AW each have an independent single-slot request engine with a 3-state FSM and an 8-bit down-counter.
  - IDLE: s_ready=1. A handshake latches all request fields and computes the delay d. The FSM goes to WAIT with cnt=d if d>0, otherwise to ISSUE.
  - WAIT: cnt decrements every cycle. At the edge where cnt==1, the FSM goes to ISSUE.
  - ISSUE: m_valid=1 with the latched fields held stable. On the m handshake the FSM returns to IDLE.
- s_ready is asserted only in IDLE. There is no same-cycle accept on issue.
- NVMM classification: nvmm = (nvmm_begin != 0) && (region >= nvmm_begin).
  - For AR, d = nvmm ? lat_fr : 0. For AW, d = nvmm ? lat_fw : 0.
  - lat_* and nvmm_begin are sampled at accept only. Later changes do not affect in-flight requests.
- W credit counter, 4 bits:
  - Increments on each m_aw handshake.
  - Decrements on each m_w handshake with wlast=1.
  - A simultaneous increment and decrement leaves it unchanged.
- W forwarding: m_wvalid = s_wvalid && credit!=0 and s_wready = m_wready && credit!=0. Data, strb and last pass combinationally.
- AW ISSUE holds m_awvalid=0 while credit==MAX_W_CREDIT, unless a wlast handshake happens in the same cycle.
- R and B channels are pure combinational wires in both directions.
- Counters increment on the downstream handshake of an NVMM-classified request and wrap modulo 2^32.

## Timing
- On reset, and immediately on sys_rst assertion mid-operation:
  - Both FSMs go to IDLE and the latched requests are dropped.
  - credit=0, counters=0.
  - s_axi_arready=s_axi_awready=1 and m_axi_arvalid=m_axi_awvalid=0.
  - m_axi_wvalid=0 and s_axi_wready=0.
- Request latency: a handshake at edge N gives m_valid high from edge N+1+d.
  - For a continuously ready slave, back-to-back throughput is one request per d+2 cycles per channel.
- In ISSUE, m_valid stays high until accepted, with no retraction and no field change (AXI rule).
- d=255 is legal: 255 WAIT cycles.
- AR and AW engines never interact. A simultaneous AR and AW in the same cycle are both accepted.

## Test plan
- DRAM read pass-through: nvmm_begin=4, AR addr=0x0800_0000 (region 1) accepted at edge 10 -> m_axi_arvalid rises at edge 11, cnt_nvmm_rd stays 0.
- NVMM read delay: nvmm_begin=4, lat_fr=20, AR addr=0x3000_0000 (region 6) at edge 10 -> m_axi_arvalid at edge 31, cnt_nvmm_rd=1, R data returns unchanged.
- NVMM write with early W: lat_fw=5, W beats presented before AW -> s_axi_wready stays 0 until the m_aw handshake, then the 8-beat burst passes and credit returns to 0 after wlast.
- Disable and latch: nvmm_begin=0 -> every request has zero delay. Separately, changing lat_fr during WAIT does not alter the release cycle.
- Backpressure and credit limit: hold m_axi_wready=0 and issue 15 AWs -> the 16th AW stays in ISSUE with m_axi_awvalid=0. One wlast handshake releases it in that same cycle.
- Reset mid-WAIT: assert sys_rst during an AR WAIT -> outputs reach their reset values asynchronously, no AR is issued afterwards, and the counters read 0.
